veg_spawn_manager: RTL and testbench

Parametrised vegetable placement engine for up to `NUM_VEG` simultaneous vegetables. It picks pseudo-random spawn positions from free-running wrap counters and rejects any candidate that overlaps the pig or another live vegetable. It retries with a directional nudge, bounded by `MAX_TRIES`. It sits between game control (spawn/despawn requests) and the renderer/collision logic, which consume the per-slot position buses.

---
 rtl/veg_spawn_manager_pkg.sv | 35 +++
 rtl/veg_spawn_manager_if.sv | 32 +++
 rtl/rect_overlap.sv | 28 ++
 rtl/veg_spawn_manager.sv | 219 +++++++++++++++++++++
 tb/tb_veg_spawn_manager.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/veg_spawn_manager_pkg.sv
// rtl/veg_spawn_manager_pkg.sv - shared playfield defaults, FSM and nudge types for the spawn manager
package veg_spawn_manager_pkg;

   // Playfield geometry shared with the renderer and collision logic
   localparam int DEF_MIN_X    = 10;
   localparam int DEF_MAX_X    = 630;
   localparam int DEF_MIN_Y    = 10;
   localparam int DEF_MAX_Y    = 470;
   localparam int DEF_VEG_SIZE = 20;
   localparam int DEF_PIG_SIZE = 40;

   typedef enum logic {
      ST_IDLE,
      ST_CHECK
   } state_t;

   typedef enum logic [2:0] {
      NUDGE_UP,
      NUDGE_DOWN,
      NUDGE_LEFT,
      NUDGE_RIGHT,
      NUDGE_RELOAD
   } nudge_t;

   // Fixed priority: up, down, left, right, else reload from the counters
   function automatic nudge_t pick_nudge(input logic can_up, input logic can_down,
                                         input logic can_left, input logic can_right);
      if (can_up)    return NUDGE_UP;
      if (can_down)  return NUDGE_DOWN;
      if (can_left)  return NUDGE_LEFT;
      if (can_right) return NUDGE_RIGHT;
      return NUDGE_RELOAD;
   endfunction

endpackage

// File: rtl/veg_spawn_manager_if.sv
// rtl/veg_spawn_manager_if.sv - spawn/clear request and slot position bus between game control and the spawn manager
interface veg_spawn_manager_if #(
   parameter int NUM_VEG = 4,
   parameter int IDX_W   = 2,
   parameter int COORD_W = 11
);
   logic                       spawn_req;
   logic [IDX_W-1:0]           spawn_idx;
   logic                       clear_req;
   logic [IDX_W-1:0]           clear_idx;
   logic [COORD_W-1:0]         pigX;
   logic [COORD_W-1:0]         pigY;
   logic [COORD_W-1:0]         pig_growth;
   logic                       busy;
   logic                       done;
   logic                       fail;
   logic [NUM_VEG-1:0]         veg_valid;
   logic [NUM_VEG*COORD_W-1:0] veg_x;
   logic [NUM_VEG*COORD_W-1:0] veg_y;

   // Game control side
   modport master (
      output spawn_req, spawn_idx, clear_req, clear_idx, pigX, pigY, pig_growth,
      input  busy, done, fail, veg_valid, veg_x, veg_y
   );

   // Spawn manager side
   modport slave (
      input  spawn_req, spawn_idx, clear_req, clear_idx, pigX, pigY, pig_growth,
      output busy, done, fail, veg_valid, veg_x, veg_y
   );
endinterface

// File: rtl/rect_overlap.sv
// rtl/rect_overlap.sv - combinational 2D square overlap test using widened unsigned sums
module rect_overlap #(
   parameter int COORD_W = 11
) (
   input  logic [COORD_W-1:0] i_ax,
   input  logic [COORD_W-1:0] i_ay,
   input  logic [COORD_W:0]   i_as,
   input  logic [COORD_W-1:0] i_bx,
   input  logic [COORD_W-1:0] i_by,
   input  logic [COORD_W:0]   i_bs,
   output logic               o_hit
);
   localparam int W = COORD_W + 2;

   logic [W-1:0] w_ax, w_ay, w_as, w_bx, w_by, w_bs;

   assign w_ax = {2'b00, i_ax};
   assign w_ay = {2'b00, i_ay};
   assign w_as = {1'b0, i_as};
   assign w_bx = {2'b00, i_bx};
   assign w_by = {2'b00, i_by};
   assign w_bs = {1'b0, i_bs};

   // Only additions are used, so edges near zero can never wrap around
   assign o_hit = ((w_ax + w_as) > w_bx) && (w_ax < (w_bx + w_bs)) &&
                  ((w_ay + w_as) > w_by) && (w_ay < (w_by + w_bs));

endmodule

// File: rtl/veg_spawn_manager.sv
// rtl/veg_spawn_manager.sv - vegetable placement engine with wrap-counter candidates and nudge retries
module veg_spawn_manager
   import veg_spawn_manager_pkg::*;
#(
   parameter int NUM_VEG   = 4,
   parameter int IDX_W     = 2,
   parameter int COORD_W   = 11,
   parameter int MIN_X     = DEF_MIN_X,
   parameter int MAX_X     = DEF_MAX_X,
   parameter int MIN_Y     = DEF_MIN_Y,
   parameter int MAX_Y     = DEF_MAX_Y,
   parameter int VEG_SIZE  = DEF_VEG_SIZE,
   parameter int PIG_SIZE  = DEF_PIG_SIZE,
   parameter int MAX_TRIES = 8,
   parameter int RESET_X   = 300,
   parameter int RESET_Y   = 300
) (
   input  logic                  clk,
   input  logic                  rst,
   veg_spawn_manager_if.slave    bus
);
   localparam int W     = COORD_W + 2;
   localparam int TRY_W = $clog2(MAX_TRIES + 1);

   localparam logic [COORD_W-1:0] LP_X_TOP    = COORD_W'(MAX_X - VEG_SIZE);
   localparam logic [COORD_W-1:0] LP_X_BOT    = COORD_W'(MIN_X);
   localparam logic [COORD_W-1:0] LP_Y_TOP    = COORD_W'(MAX_Y - VEG_SIZE);
   localparam logic [COORD_W-1:0] LP_Y_BOT    = COORD_W'(MIN_Y);
   localparam logic [COORD_W-1:0] LP_STEP     = COORD_W'(PIG_SIZE);
   localparam logic [COORD_W:0]   LP_VEG_S    = (COORD_W+1)'(VEG_SIZE);
   localparam logic [COORD_W:0]   LP_PIG_S    = (COORD_W+1)'(PIG_SIZE);
   localparam logic [W-1:0]       LP_W_STEP   = W'(PIG_SIZE);
   localparam logic [W-1:0]       LP_UP_MIN   = W'(MIN_Y + PIG_SIZE);
   localparam logic [W-1:0]       LP_DOWN_MAX = W'(MAX_Y - VEG_SIZE);
   localparam logic [W-1:0]       LP_LEFT_MIN = W'(MIN_X + PIG_SIZE);
   localparam logic [W-1:0]       LP_RIGHT_MAX= W'(MAX_X - VEG_SIZE);
   localparam logic [TRY_W-1:0]   LP_MAX_TRY  = TRY_W'(MAX_TRIES);
   localparam logic [IDX_W:0]     LP_NUM_VEG  = (IDX_W+1)'(NUM_VEG);

   // Free-running candidate sources
   logic [COORD_W-1:0] r_cnt_x, r_cnt_y;

   // Placement FSM state
   state_t             r_state;
   logic [TRY_W-1:0]   r_tries;
   logic [COORD_W-1:0] r_cand_x, r_cand_y;
   logic [IDX_W-1:0]   r_tgt;
   logic               r_busy, r_done, r_fail, r_oor_pend;

   // Slot register file
   logic [NUM_VEG-1:0] r_valid;
   logic [COORD_W-1:0] r_veg_x [NUM_VEG];
   logic [COORD_W-1:0] r_veg_y [NUM_VEG];

   logic                       w_idx_ok, w_spawn_ok, w_spawn_bad;
   logic [COORD_W:0]           w_pig_s;
   logic [COORD_W-1:0]         w_rx [NUM_VEG+1];
   logic [COORD_W-1:0]         w_ry [NUM_VEG+1];
   logic [COORD_W:0]           w_rs [NUM_VEG+1];
   logic [NUM_VEG:0]           w_hit;
   logic [NUM_VEG-1:0]         w_tgt_oh;
   logic                       w_collide, w_commit;
   logic                       w_can_up, w_can_down, w_can_left, w_can_right;
   nudge_t                     w_nudge;
   logic [NUM_VEG*COORD_W-1:0] w_veg_x_flat, w_veg_y_flat;

   assign w_idx_ok    = ({1'b0, bus.spawn_idx} < LP_NUM_VEG);
   assign w_spawn_ok  = bus.spawn_req && w_idx_ok;
   assign w_spawn_bad = bus.spawn_req && !w_idx_ok;
   assign w_pig_s     = LP_PIG_S + {1'b0, bus.pig_growth};

   // Rectangle 0 is the pig; rectangles 1..NUM_VEG are the slots
   for (genvar g = 0; g <= NUM_VEG; g++) begin : g_ovl
      if (g == 0) begin : g_pig
         assign w_rx[g] = bus.pigX;
         assign w_ry[g] = bus.pigY;
         assign w_rs[g] = w_pig_s;
      end else begin : g_veg
         assign w_rx[g] = r_veg_x[g-1];
         assign w_ry[g] = r_veg_y[g-1];
         assign w_rs[g] = LP_VEG_S;
      end
      rect_overlap #(.COORD_W(COORD_W)) u_ovl (
         .i_ax  (r_cand_x),
         .i_ay  (r_cand_y),
         .i_as  (LP_VEG_S),
         .i_bx  (w_rx[g]),
         .i_by  (w_ry[g]),
         .i_bs  (w_rs[g]),
         .o_hit (w_hit[g])
      );
   end

   // One-hot of the slot being placed, so its old position never blocks itself
   always_comb begin
      w_tgt_oh = '0;
      for (int i = 0; i < NUM_VEG; i++) begin
         w_tgt_oh[i] = (r_tgt == IDX_W'(i));
      end
   end

   assign w_collide = w_hit[0] | (|(w_hit[NUM_VEG:1] & r_valid & ~w_tgt_oh));
   assign w_commit  = (r_state == ST_CHECK) && !w_collide;

   assign w_can_up    = ({2'b00, r_cand_y} >= LP_UP_MIN);
   assign w_can_down  = (({2'b00, r_cand_y} + LP_W_STEP) <= LP_DOWN_MAX);
   assign w_can_left  = ({2'b00, r_cand_x} >= LP_LEFT_MIN);
   assign w_can_right = (({2'b00, r_cand_x} + LP_W_STEP) <= LP_RIGHT_MAX);
   assign w_nudge     = pick_nudge(w_can_up, w_can_down, w_can_left, w_can_right);

   // Wrap counters advance every cycle regardless of placement activity
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt_x <= COORD_W'(RESET_X);
         r_cnt_y <= COORD_W'(RESET_Y);
      end else begin
         r_cnt_x <= (r_cnt_x == LP_X_TOP) ? LP_X_BOT : r_cnt_x + COORD_W'(1);
         r_cnt_y <= (r_cnt_y == LP_Y_TOP) ? LP_Y_BOT : r_cnt_y + COORD_W'(1);
      end
   end

   // Placement FSM: latch a candidate, then test and nudge until clear or out of tries
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_tries    <= '0;
         r_cand_x   <= '0;
         r_cand_y   <= '0;
         r_tgt      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_fail     <= 1'b0;
         r_oor_pend <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_fail     <= r_oor_pend;
         r_oor_pend <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_spawn_bad) begin
                  r_oor_pend <= 1'b1;
               end else if (w_spawn_ok) begin
                  r_cand_x <= r_cnt_x;
                  r_cand_y <= r_cnt_y;
                  r_tgt    <= bus.spawn_idx;
                  r_tries  <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (!w_collide) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (r_tries == LP_MAX_TRY) begin
                  r_fail  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_tries <= r_tries + TRY_W'(1);
                  case (w_nudge)
                     NUDGE_UP:    r_cand_y <= r_cand_y - LP_STEP;
                     NUDGE_DOWN:  r_cand_y <= r_cand_y + LP_STEP;
                     NUDGE_LEFT:  r_cand_x <= r_cand_x - LP_STEP;
                     NUDGE_RIGHT: r_cand_x <= r_cand_x + LP_STEP;
                     default: begin
                        r_cand_x <= r_cnt_x;
                        r_cand_y <= r_cnt_y;
                     end
                  endcase
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Slot file: commit on placement success, clear on request unless it is the slot in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < NUM_VEG; i++) begin
            r_veg_x[i] <= '0;
            r_veg_y[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_VEG; i++) begin
            if (bus.clear_req && (bus.clear_idx == IDX_W'(i)) &&
                !(r_busy && (r_tgt == IDX_W'(i)))) begin
               r_valid[i] <= 1'b0;
            end
            if (w_commit && (r_tgt == IDX_W'(i))) begin
               r_valid[i] <= 1'b1;
               r_veg_x[i] <= r_cand_x;
               r_veg_y[i] <= r_cand_y;
            end
         end
      end
   end

   // Pack slot positions onto the flat renderer buses
   always_comb begin
      w_veg_x_flat = '0;
      w_veg_y_flat = '0;
      for (int i = 0; i < NUM_VEG; i++) begin
         w_veg_x_flat[i*COORD_W +: COORD_W] = r_veg_x[i];
         w_veg_y_flat[i*COORD_W +: COORD_W] = r_veg_y[i];
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.fail      = r_fail;
   assign bus.veg_valid = r_valid;
   assign bus.veg_x     = w_veg_x_flat;
   assign bus.veg_y     = w_veg_y_flat;

endmodule

// File: tb/tb_veg_spawn_manager.sv
// tb/tb_veg_spawn_manager.sv - directed self-checking bench for veg_spawn_manager
module tb_veg_spawn_manager;
   localparam int NV = 4;
   localparam int IW = 3;
   localparam int CW = 11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   veg_spawn_manager_if #(.NUM_VEG(NV), .IDX_W(IW), .COORD_W(CW)) vif ();

   veg_spawn_manager #(.NUM_VEG(NV), .IDX_W(IW), .COORD_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (vif)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CW-1:0] sx(input int i);
      return vif.veg_x[i*CW +: CW];
   endfunction

   function automatic logic [CW-1:0] sy(input int i);
      return vif.veg_y[i*CW +: CW];
   endfunction

   task automatic do_reset();
      rst            = 1'b1;
      vif.spawn_req  = 1'b0;
      vif.spawn_idx  = '0;
      vif.clear_req  = 1'b0;
      vif.clear_idx  = '0;
      vif.pigX       = 11'd2000;
      vif.pigY       = 11'd2000;
      vif.pig_growth = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (vif.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", vif.busy); end
      n_vec++; if (vif.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", vif.done); end
      n_vec++; if (vif.fail !== 1'b0) begin n_err++; $display("FAIL reset_fail: got %b want 0", vif.fail); end
      n_vec++; if (vif.veg_valid !== 4'b0000) begin n_err++; $display("FAIL reset_valid: got %b want 0000", vif.veg_valid); end
      n_vec++; if (vif.veg_x !== '0 || vif.veg_y !== '0) begin n_err++; $display("FAIL reset_pos: got %h/%h want 0/0", vif.veg_x, vif.veg_y); end
   endtask

   task automatic test_first_spawn();
      do_reset();
      vif.pigX = 11'd100; vif.pigY = 11'd100;
      vif.spawn_req = 1'b1; vif.spawn_idx = 3'd0;
      tick();
      vif.spawn_req = 1'b0;
      n_vec++; if (vif.busy !== 1'b1 || vif.done !== 1'b0) begin n_err++; $display("FAIL first_busy: got busy=%b done=%b want 1 0", vif.busy, vif.done); end
      tick();
      n_vec++; if (vif.done !== 1'b1 || vif.busy !== 1'b0 || vif.fail !== 1'b0) begin n_err++; $display("FAIL first_done: got done=%b busy=%b fail=%b want 1 0 0", vif.done, vif.busy, vif.fail); end
      n_vec++; if (vif.veg_valid !== 4'b0001) begin n_err++; $display("FAIL first_valid: got %b want 0001", vif.veg_valid); end
      n_vec++; if (sx(0) !== 11'd300 || sy(0) !== 11'd300) begin n_err++; $display("FAIL first_pos: got (%0d,%0d) want (300,300)", sx(0), sy(0)); end
      // Relocate slot0: candidate (302,302) overlaps only its own old position
      vif.spawn_req = 1'b1; vif.spawn_idx = 3'd0;
      tick();
      vif.spawn_req = 1'b0;
      tick();
      n_vec++; if (vif.done !== 1'b1 || sx(0) !== 11'd302 || sy(0) !== 11'd302) begin n_err++; $display("FAIL relocate: got done=%b (%0d,%0d) want 1 (302,302)", vif.done, sx(0), sy(0)); end
      tick();
      n_vec++; if (vif.done !== 1'b0) begin n_err++; $display("FAIL done_pulse: got %b want 0", vif.done); end
   endtask

   task automatic test_pig_nudge();
      do_reset();
      vif.pigX = 11'd290; vif.pigY = 11'd290;
      vif.spawn_req = 1'b1; vif.spawn_idx = 3'd0;
      tick();
      vif.spawn_req = 1'b0;
      tick();
      n_vec++; if (vif.done !== 1'b0 || vif.busy !== 1'b1) begin n_err++; $display("FAIL nudge_mid: got done=%b busy=%b want 0 1", vif.done, vif.busy); end
      tick();
      n_vec++; if (vif.done !== 1'b1 || vif.busy !== 1'b0) begin n_err++; $display("FAIL nudge_done: got done=%b busy=%b want 1 0", vif.done, vif.busy); end
      n_vec++; if (sx(0) !== 11'd300 || sy(0) !== 11'd260) begin n_err++; $display("FAIL nudge_pos: got (%0d,%0d) want (300,260)", sx(0), sy(0)); end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int k = 0; k < 311; k++) tick();
      vif.spawn_req = 1'b1; vif.spawn_idx = 3'd1;
      tick();
      vif.spawn_req = 1'b0;
      tick();
      n_vec++; if (vif.done !== 1'b1 || vif.veg_valid !== 4'b0010) begin n_err++; $display("FAIL wrap_done: got done=%b valid=%b want 1 0010", vif.done, vif.veg_valid); end
      n_vec++; if (sx(1) !== 11'd10 || sy(1) !== 11'd170) begin n_err++; $display("FAIL wrap_pos: got (%0d,%0d) want (10,170)", sx(1), sy(1)); end
   endtask

   task automatic test_out_of_range();
      vif.spawn_req = 1'b1; vif.spawn_idx = 3'd5;
      tick();
      vif.spawn_req = 1'b0;
      n_vec++; if (vif.busy !== 1'b0 || vif.fail !== 1'b0) begin n_err++; $display("FAIL oor_sample: got busy=%b fail=%b want 0 0", vif.busy, vif.fail); end
      tick();
      n_vec++; if (vif.fail !== 1'b1 || vif.busy !== 1'b0 || vif.done !== 1'b0) begin n_err++; $display("FAIL oor_fail: got fail=%b busy=%b done=%b want 1 0 0", vif.fail, vif.busy, vif.done); end
      n_vec++; if (vif.veg_valid !== 4'b0010) begin n_err++; $display("FAIL oor_valid: got %b want 0010", vif.veg_valid); end
      tick();
      n_vec++; if (vif.fail !== 1'b0) begin n_err++; $display("FAIL oor_pulse: got %b want 0", vif.fail); end
   endtask

   task automatic test_tries_exhausted();
      int early;
      early = 0;
      do_reset();
      vif.pigX = 11'd10; vif.pigY = 11'd10; vif.pig_growth = 11'd600;
      vif.spawn_req = 1'b1; vif.spawn_idx = 3'd2;
      tick();
      vif.spawn_req = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (vif.fail !== 1'b0 || vif.done !== 1'b0 || vif.busy !== 1'b1) early++;
      end
      n_vec++; if (early != 0) begin n_err++; $display("FAIL tries_early: got %0d bad cycles want 0", early); end
      tick();
      n_vec++; if (vif.fail !== 1'b1 || vif.done !== 1'b0 || vif.busy !== 1'b0) begin n_err++; $display("FAIL tries_fail: got fail=%b done=%b busy=%b want 1 0 0", vif.fail, vif.done, vif.busy); end
      n_vec++; if (vif.veg_valid !== 4'b0000) begin n_err++; $display("FAIL tries_valid: got %b want 0000", vif.veg_valid); end
   endtask

   task automatic test_clear_during();
      do_reset();
      vif.pigX = 11'd10; vif.pigY = 11'd10;
      vif.spawn_req = 1'b1; vif.spawn_idx = 3'd0;
      tick();
      vif.spawn_req = 1'b0;
      tick();
      n_vec++; if (vif.done !== 1'b1 || sx(0) !== 11'd300 || sy(0) !== 11'd300) begin n_err++; $display("FAIL clr_setup: got done=%b (%0d,%0d) want 1 (300,300)", vif.done, sx(0), sy(0)); end
      tick();
      vif.spawn_req = 1'b1; vif.spawn_idx = 3'd3;
      tick();
      vif.spawn_req = 1'b0;
      vif.clear_req = 1'b1; vif.clear_idx = 3'd0;
      tick();
      vif.clear_req = 1'b0;
      n_vec++; if (vif.done !== 1'b0 || vif.busy !== 1'b1 || vif.veg_valid !== 4'b0000) begin n_err++; $display("FAIL clr_mid: got done=%b busy=%b valid=%b want 0 1 0000", vif.done, vif.busy, vif.veg_valid); end
      tick();
      n_vec++; if (vif.done !== 1'b1 || vif.veg_valid !== 4'b1000) begin n_err++; $display("FAIL clr_done: got done=%b valid=%b want 1 1000", vif.done, vif.veg_valid); end
      n_vec++; if (sx(3) !== 11'd303 || sy(3) !== 11'd263) begin n_err++; $display("FAIL clr_pos: got (%0d,%0d) want (303,263)", sx(3), sy(3)); end
      // Clearing the slot in flight is ignored; a spawn_req while busy is dropped
      vif.spawn_req = 1'b1; vif.spawn_idx = 3'd3;
      tick();
      vif.spawn_idx = 3'd1;
      vif.clear_req = 1'b1; vif.clear_idx = 3'd3;
      tick();
      vif.spawn_req = 1'b0;
      vif.clear_req = 1'b0;
      n_vec++; if (vif.done !== 1'b1 || vif.veg_valid !== 4'b1000) begin n_err++; $display("FAIL clr_tgt: got done=%b valid=%b want 1 1000", vif.done, vif.veg_valid); end
      n_vec++; if (sx(3) !== 11'd306 || sy(3) !== 11'd306) begin n_err++; $display("FAIL clr_tgt_pos: got (%0d,%0d) want (306,306)", sx(3), sy(3)); end
      tick();
      n_vec++; if (vif.busy !== 1'b0) begin n_err++; $display("FAIL busy_drop: got busy=%b want 0", vif.busy); end
   endtask

   task automatic test_reset_abort();
      int spurious;
      spurious = 0;
      do_reset();
      vif.pigX = 11'd10; vif.pigY = 11'd10; vif.pig_growth = 11'd600;
      vif.spawn_req = 1'b1; vif.spawn_idx = 3'd2;
      tick();
      vif.spawn_req = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_vec++; if (vif.busy !== 1'b0 || vif.veg_valid !== 4'b0000) begin n_err++; $display("FAIL abort_state: got busy=%b valid=%b want 0 0000", vif.busy, vif.veg_valid); end
      for (int k = 0; k < 12; k++) begin
         tick();
         if (vif.fail !== 1'b0 || vif.done !== 1'b0 || vif.busy !== 1'b0) spurious++;
      end
      n_vec++; if (spurious != 0) begin n_err++; $display("FAIL abort_quiet: got %0d bad cycles want 0", spurious); end
   endtask

   initial begin
      test_reset();
      test_first_spawn();
      test_pig_nudge();
      test_wrap();
      test_out_of_range();
      test_tries_exhausted();
      test_clear_during();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
